// File: rtl/data_sram_controller_pkg.sv
// Shared types for the data SRAM controller: bus sizes, FSM states and the latched request record.
package data_sram_params;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } sram_size_t;

    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } controller_state_t;

    localparam int REQUEST_ADDRESS_WIDTH = 32;
    localparam int REQUEST_DATA_WIDTH    = 32;

    typedef struct packed {
        logic                             write;
        sram_size_t                       size;
        logic                             left;
        logic                             right;
        logic [REQUEST_ADDRESS_WIDTH-1:0] address;
        logic [REQUEST_DATA_WIDTH-1:0]    data;
    } memory_request_t;

endpackage

// File: rtl/data_sram_controller_write_align.sv
// Byte-enable and write-data placement for a 4-lane data bus.
// SWL/SWR handling is present only when DATA_SRAM_UNALIGNED_STORE_EN is defined.
module data_sram_write_align
    import data_sram_params::*;
(
    input  logic        write,
    input  sram_size_t  size,
    input  logic        left,
    input  logic        right,
    input  logic [1:0]  offset,
    input  logic [31:0] data,
    output logic [3:0]  wstrb,
    output logic [31:0] wdata,
    output sram_size_t  bus_size
);

`ifndef DATA_SRAM_UNALIGNED_STORE_EN
    logic unused_unaligned;
    assign unused_unaligned = left ^ right;
`endif

    always_comb begin
        bus_size = size;
        wdata    = data;
        wstrb    = 4'b1111;
        case (size)
            SIZE_BYTE: begin
                wstrb = 4'b0001 << offset;
                wdata = {4{data[7:0]}};
            end
            SIZE_HALF: begin
                wstrb = 4'b0011 << {offset[1], 1'b0};
                wdata = {2{data[15:0]}};
            end
            default: ;
        endcase
`ifdef DATA_SRAM_UNALIGNED_STORE_EN
        // Partial-word stores go out as word-sized accesses at the original address.
        if (left) begin
            bus_size = SIZE_WORD;
            wstrb    = 4'b1111 >> (2'd3 - offset);
            wdata    = data >> {(2'd3 - offset), 3'b000};
        end else if (right) begin
            bus_size = SIZE_WORD;
            wstrb    = 4'b1111 << offset;
            wdata    = data << {offset, 3'b000};
        end
`endif
        if (!write) begin
            wstrb = 4'b0000;
        end
    end

endmodule

// File: rtl/data_sram_controller.sv
// In-order load/store sequencer for the SRAM-like data bus with flush-aware response discarding.
// Optional SWL/SWR support: define DATA_SRAM_UNALIGNED_STORE_EN.
module data_sram_controller
    import data_sram_params::*;
#(
    parameter int MAX_OUTSTANDING = 4,
    parameter int ADDRESS_WIDTH   = 32,
    parameter int DATA_WIDTH      = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     request_valid,
    output logic                     request_ready,
    input  logic                     request_write,
    input  logic [1:0]               request_size,
    input  logic                     request_left,
    input  logic                     request_right,
    input  logic [ADDRESS_WIDTH-1:0] request_address,
    input  logic [DATA_WIDTH-1:0]    request_write_data,
    input  logic                     flush,
    output logic                     response_valid,
    output logic [DATA_WIDTH-1:0]    response_data,
    output logic                     idle,
    output logic                     data_sram_req,
    output logic                     data_sram_wr,
    output logic [1:0]               data_sram_size,
    output logic [3:0]               data_sram_wstrb,
    output logic [ADDRESS_WIDTH-1:0] data_sram_addr,
    output logic [DATA_WIDTH-1:0]    data_sram_wdata,
    input  logic                     data_sram_addr_ok,
    input  logic                     data_sram_data_ok,
    input  logic [DATA_WIDTH-1:0]    data_sram_rdata
);

    localparam int COUNT_WIDTH = $clog2(MAX_OUTSTANDING + 1);
    localparam logic [COUNT_WIDTH-1:0] COUNT_MAX = COUNT_WIDTH'(MAX_OUTSTANDING);

    controller_state_t        state, next_state;
    memory_request_t          incoming, latched;
    logic [3:0]               aligned_wstrb, latched_wstrb;
    logic [31:0]              aligned_wdata;
    sram_size_t               aligned_size;
    logic [COUNT_WIDTH-1:0]   outstanding, outstanding_next, discard_count;
    logic                     cancel;
    logic                     accept, addr_fire, data_fire;

    data_sram_write_align u_write_align (
        .write    (request_write),
        .size     (sram_size_t'(request_size)),
        .left     (request_left),
        .right    (request_right),
        .offset   (request_address[1:0]),
        .data     (32'(request_write_data)),
        .wstrb    (aligned_wstrb),
        .wdata    (aligned_wdata),
        .bus_size (aligned_size)
    );

    always_comb begin
        incoming.write   = request_write;
        incoming.size    = aligned_size;
        incoming.left    = request_left;
        incoming.right   = request_right;
        incoming.address = REQUEST_ADDRESS_WIDTH'(request_address);
        incoming.data    = aligned_wdata;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // The bus must see req held with stable fields until addr_ok, even across a flush.
    always_comb begin
        next_state    = state;
        accept        = 1'b0;
        addr_fire     = 1'b0;
        data_sram_req = 1'b0;
        request_ready = 1'b0;
        case (state)
            IDLE: begin
                if (request_valid && !flush && outstanding < COUNT_MAX) begin
                    accept     = 1'b1;
                    next_state = ISSUE;
                end
            end
            ISSUE: begin
                data_sram_req = 1'b1;
                if (data_sram_addr_ok) begin
                    addr_fire     = 1'b1;
                    request_ready = !(cancel || flush);
                    next_state    = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign data_fire        = data_sram_data_ok && (outstanding != '0);
    assign outstanding_next = outstanding + COUNT_WIDTH'(addr_fire) - COUNT_WIDTH'(data_fire);

    always_ff @(posedge clock) begin
        if (reset) begin
            latched       <= '0;
            latched_wstrb <= 4'b0000;
        end else if (accept) begin
            latched       <= incoming;
            latched_wstrb <= aligned_wstrb;
        end
    end

    // On flush every transaction still owed a response is marked for discard.
    always_ff @(posedge clock) begin
        if (reset) begin
            outstanding    <= '0;
            discard_count  <= '0;
            cancel         <= 1'b0;
            response_valid <= 1'b0;
            response_data  <= '0;
        end else begin
            outstanding <= outstanding_next;
            if (flush) begin
                discard_count <= outstanding_next;
            end else begin
                discard_count <= discard_count
                               + COUNT_WIDTH'(addr_fire && cancel)
                               - COUNT_WIDTH'(data_fire && discard_count != '0);
            end
            if (addr_fire) begin
                cancel <= 1'b0;
            end else if (state == ISSUE && flush) begin
                cancel <= 1'b1;
            end
            response_valid <= data_fire && (discard_count == '0);
            if (data_fire && discard_count == '0) begin
                response_data <= data_sram_rdata;
            end
        end
    end

    assign data_sram_wr    = latched.write;
    assign data_sram_size  = latched.size;
    assign data_sram_wstrb = latched_wstrb;
    assign data_sram_addr  = ADDRESS_WIDTH'(latched.address);
    assign data_sram_wdata = DATA_WIDTH'(latched.data);
    assign idle            = (state == IDLE) && (outstanding == '0);

endmodule

// File: doc/data_sram_controller.md
# data_sram_controller

Sequences every load and store from the memory stage onto the SRAM-like data bus (req / addr_ok / data_ok). It holds each request stable until the bus accepts it and tracks in-order outstanding transactions up to a fixed depth. It also discards responses that belong to transactions cancelled by an exception or eret flush from writeback. It sits between the execute/memory pipeline boundary and the data SRAM port, replacing ad-hoc pending-load counting in the pipeline stages.

## Interface
Parameters:
- MAX_OUTSTANDING, 4, maximum accepted-but-unanswered transactions (≥1)
- ADDRESS_WIDTH, 32, bus address width
- DATA_WIDTH, 32, bus data width (fixed 4 byte lanes)

Ports:
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- request_valid  in  1  pipeline has a memory op; held until request_ready
- request_ready  out  1  one-cycle pulse: request accepted by bus
- request_write  in  1  1 = store, 0 = load
- request_size  in  2  0 byte, 1 half, 2 word
- request_left / request_right  in  1 each  SWL / SWR (see Configuration)
- request_address  in  ADDRESS_WIDTH  byte address
- request_write_data  in  DATA_WIDTH  unaligned store data (rt)
- flush  in  1  writeback exception_valid | eret_flush
- response_valid  out  1  load/store completion for a live transaction
- response_data  out  DATA_WIDTH  raw rdata (lane extraction done by stage)
- idle  out  1  no transaction in ISSUE and outstanding count 0
- data_sram_req / data_sram_wr  out  1 each  bus request, write flag
- data_sram_size  out  2  bus size
- data_sram_wstrb  out  4  byte enables (0 for reads)
- data_sram_addr  out  ADDRESS_WIDTH;  data_sram_wdata  out  DATA_WIDTH
- data_sram_addr_ok / data_sram_data_ok  in  1 each  bus handshakes
- data_sram_rdata  in  DATA_WIDTH  read data

## Operation
- FSM states:
  - IDLE:
    - latch request fields, wstrb and wdata when request_valid & !flush & outstanding < MAX_OUTSTANDING; go ISSUE.
  - ISSUE:
    - data_sram_req=1 with latched fields held constant.
    - On addr_ok: outstanding++, return to IDLE, pulse request_ready unless the request is cancelled.
- Bus rule: once req rises it stays high with unchanged fields until addr_ok, even across flush.
- Flush in ISSUE sets a cancel flag; on addr_ok the transaction is counted in both outstanding and discard, with no request_ready.
- Flush in IDLE: nothing latched that cycle.
- Any flush: discard_count <= outstanding, adjusted for same-cycle addr_ok (+1) and data_ok (−1).
- data_ok:
  - outstanding−−.
  - If discard_count>0: discard_count−−, no response.
  - Else: register response_valid=1 and response_data=rdata.
- Strobes and data:
  - Byte: wstrb = 0001<<addr[1:0], data replicated ×4.
  - Half: wstrb = 0011<<{addr[1],0}, data replicated ×2.
  - Word: wstrb = 1111.
- data_ok with outstanding==0 is ignored; counters never underflow.
- Counters are $clog2(MAX_OUTSTANDING+1) bits.

## Timing
- Reset: state IDLE, outstanding and discard 0, cancel 0.
- All outputs 0 after reset, except idle=1.
- Request latency: req rises the cycle after acceptance in IDLE; request_ready in the addr_ok cycle.
- Back-to-back issue: minimum 2 cycles per request (IDLE→ISSUE).
- Response: response_valid one cycle after data_ok, one-cycle pulse; one per data_ok at most.
- Full: at outstanding==MAX_OUTSTANDING, IDLE waits; a same-cycle data_ok frees a slot only from the next cycle.
- Reset mid-transaction: counters cleared immediately; the bus is reset alongside, so no stale data_ok is expected.

## Configuration
- DATA_SRAM_UNALIGNED_STORE_EN defined: request_left / request_right honoured.
  - SWL wstrb by addr[1:0]: 00→0001, 01→0011, 10→0111, 11→1111; wdata = rt >> 8·(3−a).
  - SWR wstrb by addr[1:0]: 00→1111, 01→1110, 10→1100, 11→1000; wdata = rt << 8·a.
  - data_sram_size=2 for both, address unmodified.
- Undefined: left/right inputs ignored; request follows request_size only.

## Structure
- Package data_sram_params:
  - sram_size_t enum (SIZE_BYTE, SIZE_HALF, SIZE_WORD)
  - controller_state_t (IDLE, ISSUE)
  - memory_request_t struct (write, size, left, right, address, data)
- Sub-module data_sram_write_align: combinational wstrb/wdata generation, including the macro-gated unaligned cases.

## Test plan
- Load word at 0x100, addr_ok after 2 cycles, data_ok rdata 0xDEADBEEF 3 cycles later → one request_ready, response_valid with 0xDEADBEEF the next cycle, idle=1 after.
- Store byte 0xAB at 0x103 → wstrb 1000, wdata 0xABABABAB, wr=1, size 0.
- Four loads with data_ok held off → fifth waits in IDLE with req low; one data_ok → fifth issues.
- Three outstanding loads, flush → next three data_ok give no response_valid; a fresh load then returns normally.
- Flush while req is held waiting for addr_ok → req stays high, no request_ready, its data_ok is discarded.
- With the macro, SWR at 0x201, rt 0x11223344 → wstrb 1110, wdata 0x22334400.
